// File: rtl/seg_bcd_counter.sv
// -----------------------------------------------------------------------------
// seg_bcd_counter
// Prescaled, cascaded up/down BCD counter intended to drive a multi-digit
// seven-segment display.
//
// A prescaler divides the clock so that the digit chain advances once every
// PRESCALE_MAX+1 enabled cycles. The digit chain counts up or down in BCD.
// Carry and borrow ripple through all digits inside the same cycle.
//
// Parameters
//   DIGITS       number of cascaded BCD digits (1..8)
//   PRESCALE_MAX prescaler terminal value; must fit in PRE_W bits
//   PRE_W        prescaler counter width
//
// Ports
//   clk       rising-edge clock for all state
//   reset     synchronous active-high reset (highest priority)
//   enable    high: prescaler advances; low: everything holds
//   up_dn     1 = count up, 0 = count down; sampled on tick cycles
//   clear     synchronous clear of the digits and the prescaler
//   load      synchronous load of load_val (nibbles above 9 load as 9)
//   load_val  packed BCD load value, digit 0 in bits [3:0]
//   digits    registered packed BCD count, digit 0 in bits [3:0]
//   tick      combinational: the digit chain advances on this cycle's edge
//   wrap      combinational: tick while the whole counter is at its terminal
//             value for the current direction
// -----------------------------------------------------------------------------
module seg_bcd_counter #(
    parameter int DIGITS       = 4,
    parameter int PRESCALE_MAX = 10,
    parameter int PRE_W        = 30
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up_dn,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  tick,
    output logic                  wrap
);

    localparam logic [PRE_W-1:0] PRE_TERM = PRE_W'(PRESCALE_MAX);

    logic [PRE_W-1:0]    pre_r;
    logic [4*DIGITS-1:0] digits_r;
    logic [4*DIGITS-1:0] next_digits_s;
    logic [4*DIGITS-1:0] load_sat_s;
    logic                carry_s;
    logic                terminal_s;
    logic                tick_s;
    logic                wrap_s;

    // Clamp an out-of-range nibble to 9 so the digit registers stay legal BCD.
    function automatic logic [3:0] bcd_sat(input logic [3:0] n);
        if (n > 4'd9) begin
            return 4'd9;
        end else begin
            return n;
        end
    endfunction

    // Advance one BCD digit by one step in the given direction, with wrap.
    function automatic logic [3:0] bcd_step(input logic [3:0] n, input logic up);
        if (up) begin
            return (n >= 4'd9) ? 4'd0 : n + 4'd1;
        end else begin
            return (n == 4'd0) ? 4'd9 : n - 4'd1;
        end
    endfunction

    // Digit chain next state: a digit moves only while every lower digit sits
    // at its rollover value (9 counting up, 0 counting down). carry_s ends up
    // high only when every digit is at rollover, i.e. the counter is terminal.
    always_comb begin
        next_digits_s = digits_r;
        load_sat_s    = load_val;
        carry_s       = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            load_sat_s[4*k +: 4] = bcd_sat(load_val[4*k +: 4]);
            if (carry_s) begin
                next_digits_s[4*k +: 4] = bcd_step(digits_r[4*k +: 4], up_dn);
            end else begin
                next_digits_s[4*k +: 4] = digits_r[4*k +: 4];
            end
            if (up_dn) begin
                carry_s = carry_s && (digits_r[4*k +: 4] == 4'd9);
            end else begin
                carry_s = carry_s && (digits_r[4*k +: 4] == 4'd0);
            end
        end
        terminal_s = carry_s;
    end

    // Tick and wrap are suppressed by every higher-priority control so they
    // only ever announce an edge on which the digit chain really advances.
    always_comb begin
        tick_s = !reset && enable && !clear && !load && (pre_r == PRE_TERM);
        wrap_s = tick_s && terminal_s;
    end

    assign tick   = tick_s;
    assign wrap   = wrap_s;
    assign digits = digits_r;

    // Prescaler and digit registers, priority: reset, clear, load, tick, hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_r    <= {PRE_W{1'b0}};
            digits_r <= {(4*DIGITS){1'b0}};
        end else if (clear) begin
            pre_r    <= {PRE_W{1'b0}};
            digits_r <= {(4*DIGITS){1'b0}};
        end else if (load) begin
            pre_r    <= {PRE_W{1'b0}};
            digits_r <= load_sat_s;
        end else if (tick_s) begin
            pre_r    <= {PRE_W{1'b0}};
            digits_r <= next_digits_s;
        end else if (enable) begin
            pre_r    <= pre_r + PRE_W'(1);
            digits_r <= digits_r;
        end else begin
            pre_r    <= pre_r;
            digits_r <= digits_r;
        end
    end

endmodule

// File: tb/tb_seg_bcd_counter.sv
// -----------------------------------------------------------------------------
// tb_seg_bcd_counter
// Self-checking bench for seg_bcd_counter with DIGITS=2, PRESCALE_MAX=2.
// A decimal reference model predicts tick/wrap for the current cycle (checked
// directly before the edge) and the digits after the edge (pushed to a
// scoreboard queue and popped once the DUT has registered them).
// -----------------------------------------------------------------------------
module tb_seg_bcd_counter;

    localparam int DIGITS = 2;
    localparam int PMAX   = 2;
    localparam int MODV   = 100;

    logic                clk = 1'b0;
    logic                reset, enable, up_dn, clear, load;
    logic [4*DIGITS-1:0] load_val;
    logic [4*DIGITS-1:0] digits;
    logic                tick, wrap;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int m_pre = 0;
    int m_val = 0;

    logic [7:0] exp_q[$];

    seg_bcd_counter #(.DIGITS(DIGITS), .PRESCALE_MAX(PMAX), .PRE_W(30)) dut (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn),
        .clear(clear), .load(load), .load_val(load_val),
        .digits(digits), .tick(tick), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[3:0] = 4'(v % 10);
        r[7:4] = 4'((v / 10) % 10);
        return r;
    endfunction

    function automatic int from_bcd_sat(input logic [7:0] b);
        int lo, hi;
        lo = int'(b[3:0]);
        hi = int'(b[7:4]);
        if (lo > 9) lo = 9;
        if (hi > 9) hi = 9;
        return hi * 10 + lo;
    endfunction

    // One clock cycle: inputs are already driven; check comb outputs, advance
    // the model, queue the expected digits, then compare after the edge.
    task automatic step(input string tag);
        bit e_tick, e_wrap;
        logic [7:0] e_dig;
        #1;
        e_tick = !reset && !clear && !load && enable && (m_pre == PMAX);
        e_wrap = e_tick && ((up_dn && m_val == MODV - 1) || (!up_dn && m_val == 0));
        check_eq({tag, ".tick"}, 32'(tick), 32'(e_tick));
        check_eq({tag, ".wrap"}, 32'(wrap), 32'(e_wrap));
        if (reset || clear) begin
            m_pre = 0; m_val = 0;
        end else if (load) begin
            m_pre = 0; m_val = from_bcd_sat(load_val);
        end else if (enable) begin
            if (m_pre == PMAX) begin
                m_pre = 0;
                m_val = up_dn ? (m_val + 1) % MODV : (m_val + MODV - 1) % MODV;
            end else begin
                m_pre = m_pre + 1;
            end
        end
        exp_q.push_back(to_bcd(m_val));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            e_dig = exp_q.pop_front();
            check_eq({tag, ".digits"}, 32'(digits), 32'(e_dig));
        end
    endtask

    task automatic drive(input bit r, input bit en, input bit ud, input bit cl,
                         input bit ld, input logic [7:0] lv);
        reset = r; enable = en; up_dn = ud; clear = cl; load = ld; load_val = lv;
    endtask

    task automatic run(input string tag, input int n, input bit en, input bit ud);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, en, ud, 1'b0, 1'b0, 8'h00);
            step(tag);
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        // reset (with enable/clear/load also high: reset must win)
        step("reset");
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h55);
        step("reset_override");

        // count up from zero through 0x10, no wrap
        run("count_up", 33, 1'b1, 1'b1);

        // load 0x99, one tick up -> wrap, digits 0x00
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h99);
        step("load99");
        run("wrap_up", 3, 1'b1, 1'b1);

        // load 0x10 counting down to 0x00, then wrap to 0x99
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h10);
        step("load10");
        run("count_dn", 33, 1'b1, 1'b0);

        // saturating load and clear-over-load priority
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hAF);
        step("load_af");
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h42);
        step("clear_load");

        // hold with prescaler at 1, then resume
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h37);
        step("load37");
        run("pre_to_1", 1, 1'b1, 1'b1);
        run("hold", 10, 1'b0, 1'b1);
        run("resume", 4, 1'b1, 1'b1);

        // reset mid-prescale at 0x57
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h57);
        step("load57");
        run("pre_to_2", 2, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        step("reset_mid");
        run("after_reset", 7, 1'b1, 1'b1);

        // direction change between ticks
        run("dir_up", 4, 1'b1, 1'b1);
        run("dir_dn", 6, 1'b1, 1'b0);

        // random mix of controls
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 29) == 0), 8'($urandom_range(0, 255)));
            step("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seg_bcd_counter.md
SEG_BCD_COUNTER -- requirements
Module: seg_bcd_counter

Interface
REQ-001 SHALL provide parameter DIGITS, default 4, number of cascaded BCD digits (1..8).
REQ-002 SHALL provide parameter PRESCALE_MAX, default 10, prescaler terminal value; one digit tick every PRESCALE_MAX+1 enabled cycles.
REQ-003 SHALL provide parameter PRE_W, default 30, prescaler counter width; PRESCALE_MAX SHALL fit in PRE_W bits.
REQ-004 SHALL provide port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL provide port enable  input  1  high: prescaler advances; low: prescaler and digits hold.
REQ-007 SHALL provide port up_dn  input  1  1 = count up, 0 = count down; sampled on tick cycles.
REQ-008 SHALL provide port clear  input  1  synchronous clear of digits and prescaler.
REQ-009 SHALL provide port load  input  1  synchronous load of load_val into digits.
REQ-010 SHALL provide port load_val  input  4*DIGITS  packed BCD load value, digit 0 in bits [3:0].
REQ-011 SHALL provide port digits  output  4*DIGITS  packed BCD count, digit 0 (least significant) in bits [3:0].
REQ-012 SHALL provide port tick  output  1  combinational pulse: prescaler at PRESCALE_MAX and enable high.
REQ-013 SHALL provide port wrap  output  1  combinational pulse: tick while whole counter at terminal value for current direction.

Function
REQ-014 Prescaler SHALL increment by 1 each cycle enable is high, and return to 0 on the cycle after it equals PRESCALE_MAX with enable high.
REQ-015 tick SHALL equal (prescaler == PRESCALE_MAX) && enable && !clear && !load; no registered latency.
REQ-016 On tick with up_dn=1: digit 0 SHALL increment; digit k (k>0) SHALL increment only when digits 0..k-1 all equal 9; any digit at 9 that increments SHALL become 0.
REQ-017 On tick with up_dn=0: digit 0 SHALL decrement; digit k SHALL decrement only when digits 0..k-1 all equal 0; any digit at 0 that decrements SHALL become 9.
REQ-018 Carry/borrow ripple SHALL resolve within the tick cycle; all digits update on the same edge.
REQ-019 wrap SHALL be high on tick when up_dn=1 and all digits equal 9, or up_dn=0 and all digits equal 0; counter then wraps to all-0 or all-9 respectively.
REQ-020 Priority, highest first: reset, clear, load, tick, hold.
REQ-021 clear SHALL set all digits and prescaler to 0 on the next edge, regardless of enable.
REQ-022 load SHALL copy load_val into digits and set prescaler to 0 on the next edge, regardless of enable.
REQ-023 Any load_val nibble greater than 9 SHALL be loaded as 9.
REQ-024 With enable low and no clear/load, prescaler and digits SHALL hold; tick and wrap SHALL be 0.
REQ-025 Digit registers SHALL never hold a value greater than 9.
REQ-026 Changing up_dn between ticks SHALL take effect on the next tick with no state disturbance.

Reset
REQ-027 With reset high at a rising edge, prescaler and all digits SHALL become 0 on that edge.
REQ-028 Reset SHALL override enable, clear and load; tick and wrap SHALL be 0 on any cycle reset is high.
REQ-029 Reset asserted mid-prescale or mid-ripple SHALL leave no residual state; counting restarts from prescaler 0 after release.

Verification (DIGITS=2, PRESCALE_MAX=2 unless stated)
REQ-030 Reset release, enable=1, up_dn=1 -> tick every 3rd cycle; digits 0x00, 0x01 ... 0x09, then 0x10; no wrap.
REQ-031 load_val=0x99, up_dn=1, wait one tick -> wrap=1 on that tick, digits 0x00 next cycle.
REQ-032 load_val=0x10, up_dn=0, two ticks -> digits 0x09 then 0x08; at 0x00 next tick -> wrap=1, digits 0x99.
REQ-033 load_val=0xAF -> digits 0x99 after load; clear and load same cycle -> digits 0x00.
REQ-034 enable low 10 cycles with prescaler=1 -> digits and prescaler hold, tick=0; re-enable -> tick 2 cycles later.
REQ-035 reset pulsed 1 cycle while prescaler=2 at digits 0x57 -> digits 0x00, prescaler 0, first tick 3 enabled cycles after release.
